npc_adder: RTL and testbench



---
 rtl/npc_adder.sv | 74 +++++++
 tb/tb_npc_adder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/npc_adder.sv
// rtl/npc_adder.sv - registered next-PC adder for the SPARC datapath
//
// Loads either in + STEP or in unchanged into the next-PC register whenever
// nPC_ADD is high; all outputs are registered, nothing is combinational from
// the inputs.
//
// Parameters:
//   WIDTH     data path width in bits (>= 2)
//   STEP      increment applied when sel=1, in bytes (must be below 2^WIDTH)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in        source address (current nPC)
//   sel       1: load in + STEP, 0: load in unchanged
//   nPC_ADD   load enable
//   out       registered next-PC value
//   out_valid high once at least one load has happened since reset
//   wrap      carry-out of the increment for the most recent load
//   misalign  (NPC_ADDER_ALIGN_CHECK_EN only) loaded out[1:0] != 2'b00
//
// Build option: define NPC_ADDER_ALIGN_CHECK_EN to add the misalign port and
// its register; otherwise no alignment logic exists.

module npc_adder #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             sel,
    input  logic             nPC_ADD,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             wrap
`ifdef NPC_ADDER_ALIGN_CHECK_EN
    ,
    output logic             misalign
`endif
);

    localparam logic [WIDTH:0] STEP_EXT = (WIDTH + 1)'(STEP);

    // One extra bit so the carry-out of the increment can be captured as wrap.
    logic [WIDTH:0] sum_ext;

    always_comb begin
        sum_ext = {1'b0, in} + (sel ? STEP_EXT : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
        end else if (nPC_ADD) begin
            out       <= sum_ext[WIDTH-1:0];
            out_valid <= 1'b1;
            wrap      <= sum_ext[WIDTH];
        end
    end

`ifdef NPC_ADDER_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign <= 1'b0;
        end else if (nPC_ADD) begin
            misalign <= (sum_ext[1:0] != 2'b00);
        end
    end
`endif

endmodule

// File: tb/tb_npc_adder.sv
// tb/tb_npc_adder.sv - self-checking bench for npc_adder

`timescale 1ns/1ps

module tb_npc_adder;

    logic        clk;
    logic        rst_n;
    logic [31:0] in;
    logic        sel;
    logic        nPC_ADD;
    logic [31:0] out;
    logic        out_valid;
    logic        wrap;
`ifdef NPC_ADDER_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int passed = 0;
    int total  = 0;

    // Reference model state
    logic [31:0] m_out;
    logic        m_valid;
    logic        m_wrap;
    logic        m_mis;

    npc_adder #(.WIDTH(32), .STEP(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .sel       (sel),
        .nPC_ADD   (nPC_ADD),
        .out       (out),
        .out_valid (out_valid),
        .wrap      (wrap)
`ifdef NPC_ADDER_ALIGN_CHECK_EN
        ,
        .misalign  (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus at the falling edge, let the rising edge
    // happen, and update the model from the address arithmetic.
    task automatic drive_edge(input logic [31:0] i, input logic s, input logic e);
        longint unsigned t;
        @(negedge clk);
        in      = i;
        sel     = s;
        nPC_ADD = e;
        @(posedge clk);
        #1;
        if (e && rst_n) begin
            t       = longint'(i) + (s ? 64'd4 : 64'd0);
            m_out   = 32'(t % 64'h1_0000_0000);
            m_wrap  = (t >= 64'h1_0000_0000);
            m_valid = 1'b1;
            m_mis   = ((t % 4) != 0);
        end
    endtask

    task automatic model_reset();
        m_out   = '0;
        m_valid = 1'b0;
        m_wrap  = 1'b0;
        m_mis   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        in      = 32'hDEAD_BEEF;
        sel     = 1'b1;
        nPC_ADD = 1'b1;
        model_reset();
        #3;
        total++; if (out !== 32'h0) $display("FAIL reset_out got=%h exp=0", out); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else passed++;
        total++; if (wrap !== 1'b0) $display("FAIL reset_wrap got=%b exp=0", wrap); else passed++;
`ifdef NPC_ADDER_ALIGN_CHECK_EN
        total++; if (misalign !== 1'b0) $display("FAIL reset_misalign got=%b exp=0", misalign); else passed++;
`endif
        // Enabled edge while reset held: reset wins
        @(posedge clk); #1;
        total++; if (out !== 32'h0) $display("FAIL reset_wins_out got=%h exp=0", out); else passed++;
        @(negedge clk);
        nPC_ADD = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic test_basic();
        drive_edge(32'd5, 1'b1, 1'b1);
        total++; if (out !== 32'd9) $display("FAIL basic_out got=%h exp=9", out); else passed++;
        total++; if (wrap !== 1'b0) $display("FAIL basic_wrap got=%b exp=0", wrap); else passed++;
        total++; if (out_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", out_valid); else passed++;
`ifdef NPC_ADDER_ALIGN_CHECK_EN
        total++; if (misalign !== 1'b1) $display("FAIL basic_misalign got=%b exp=1", misalign); else passed++;
`endif
        drive_edge(32'd5, 1'b0, 1'b0);
        drive_edge(32'h1234_5678, 1'b1, 1'b0);
        total++; if (out !== 32'd9) $display("FAIL hold_out got=%h exp=9", out); else passed++;
        drive_edge(32'd5, 1'b0, 1'b1);
        total++; if (out !== 32'd5) $display("FAIL passthru_out got=%h exp=5", out); else passed++;
    endtask

    task automatic test_wrap();
        drive_edge(32'hFFFF_FFFC, 1'b1, 1'b1);
        total++; if (out !== 32'h0) $display("FAIL wrap_out got=%h exp=0", out); else passed++;
        total++; if (wrap !== 1'b1) $display("FAIL wrap_flag got=%b exp=1", wrap); else passed++;
        drive_edge(32'h100, 1'b0, 1'b1);
        total++; if (out !== 32'h100) $display("FAIL unwrap_out got=%h exp=100", out); else passed++;
        total++; if (wrap !== 1'b0) $display("FAIL unwrap_flag got=%b exp=0", wrap); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'h1004;
        exp_seq[1] = 32'h2004;
        exp_seq[2] = 32'h3004;
        for (int k = 0; k < 3; k++) begin
            drive_edge(32'h1000 * (k + 1), 1'b1, 1'b1);
            total++;
            if (out !== exp_seq[k]) $display("FAIL b2b_%0d got=%h exp=%h", k, out, exp_seq[k]);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        drive_edge(32'h40, 1'b0, 1'b1);
        total++; if (out !== 32'h40) $display("FAIL pre_reset_out got=%h exp=40", out); else passed++;
        // Mid-cycle, away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        total++; if (out !== 32'h0) $display("FAIL async_reset_out got=%h exp=0", out); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL async_reset_valid got=%b exp=0", out_valid); else passed++;
        @(negedge clk);
        nPC_ADD = 1'b0;
        rst_n   = 1'b1;
        drive_edge(32'h77, 1'b1, 1'b0);
        drive_edge(32'h78, 1'b0, 1'b0);
        total++; if (out !== 32'h0) $display("FAIL post_reset_hold_out got=%h exp=0", out); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL post_reset_hold_valid got=%b exp=0", out_valid); else passed++;
        drive_edge(32'h20, 1'b1, 1'b1);
        total++; if (out !== 32'h24) $display("FAIL first_load_out got=%h exp=24", out); else passed++;
    endtask

`ifdef NPC_ADDER_ALIGN_CHECK_EN
    task automatic test_misalign();
        drive_edge(32'h10, 1'b1, 1'b1);
        total++; if (out !== 32'h14) $display("FAIL align_out got=%h exp=14", out); else passed++;
        total++; if (misalign !== 1'b0) $display("FAIL align_flag got=%b exp=0", misalign); else passed++;
        drive_edge(32'h11, 1'b1, 1'b1);
        total++; if (misalign !== 1'b1) $display("FAIL misalign_flag got=%b exp=1", misalign); else passed++;
    endtask
`endif

    task automatic test_random();
        logic [31:0] i;
        logic        s;
        logic        e;
        for (int n = 0; n < 300; n++) begin
            i = $urandom;
            if ($urandom_range(0, 7) == 0) i = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            s = 1'($urandom_range(0, 1));
            e = ($urandom_range(0, 9) < 7);
            drive_edge(i, s, e);
            total++;
            if (out !== m_out || out_valid !== m_valid || wrap !== m_wrap)
                $display("FAIL random_%0d got out=%h v=%b w=%b exp out=%h v=%b w=%b",
                         n, out, out_valid, wrap, m_out, m_valid, m_wrap);
            else passed++;
`ifdef NPC_ADDER_ALIGN_CHECK_EN
            total++;
            if (misalign !== m_mis) $display("FAIL random_mis_%0d got=%b exp=%b", n, misalign, m_mis);
            else passed++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_async_reset();
`ifdef NPC_ADDER_ALIGN_CHECK_EN
        test_misalign();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
